// File: rtl/noc_flit_arbiter.sv
// Round-robin wormhole arbiter that locks one flit source per packet onto a router port.
// Optional idle-source release is built when NOC_FLIT_ARB_TIMEOUT_EN is defined.
module noc_flit_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FLIT_W         = 8,
  parameter int MAX_FLITS      = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      hdr_err,
  output logic                      len_err,
  output logic [15:0]               pkt_count
`ifdef NOC_FLIT_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_FLITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   flit_cnt;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [FLIT_W-1:0] win_flit;
  logic [FLIT_W-1:0] lk_flit;
  logic            win_hdr;
  logic            out_free;
  logic            accept;
  logic            is_tail;
  logic            at_max;

`ifdef NOC_FLIT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   idle_cnt;
`endif

  // Search starts one past the last released source.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign win_flit = req_flit[int'(winner)*FLIT_W +: FLIT_W];
  assign lk_flit  = req_flit[int'(grant_id)*FLIT_W +: FLIT_W];
  assign win_hdr  = (win_flit[7:2] == 6'b101111);
  assign out_free = ~out_valid | out_ready;
  assign accept   = (state == LOCKED) && req_valid[grant_id] && out_free;
  assign is_tail  = (lk_flit == 8'hFF);
  assign at_max   = (flit_cnt == CW'(MAX_FLITS - 1));
  assign busy     = (state == LOCKED);

  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == LOCKED)
        req_ready[grant_id] = out_free;
      else if (found && !win_hdr)
        req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      flit_cnt  <= '0;
      grant_id  <= '0;
      out_flit  <= '0;
      out_valid <= 1'b0;
      hdr_err   <= 1'b0;
      len_err   <= 1'b0;
      pkt_count <= '0;
`ifdef NOC_FLIT_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      hdr_err <= 1'b0;
      len_err <= 1'b0;
`ifdef NOC_FLIT_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (accept) begin
        out_flit  <= lk_flit;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            if (win_hdr) begin
              grant_id <= winner;
              flit_cnt <= '0;
              state    <= LOCKED;
`ifdef NOC_FLIT_ARB_TIMEOUT_EN
              idle_cnt <= '0;
`endif
            end else begin
              hdr_err <= 1'b1;
              rr_ptr  <= winner;
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            flit_cnt <= flit_cnt + 1'b1;
            if (is_tail) begin
              state     <= IDLE;
              rr_ptr    <= grant_id;
              pkt_count <= pkt_count + 16'd1;
            end else if (at_max) begin
              state   <= IDLE;
              rr_ptr  <= grant_id;
              len_err <= 1'b1;
            end
          end
`ifdef NOC_FLIT_ARB_TIMEOUT_EN
          if (req_valid[grant_id]) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            rr_ptr      <= grant_id;
            timeout_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_flit_arbiter.sv
// Directed-vector bench for noc_flit_arbiter (default build, 4 sources, 8-bit flits).
module tb_noc_flit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_flit;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        hdr_err;
  logic        len_err;
  logic [15:0] pkt_count;

  noc_flit_arbiter dut (
    .clk(clk), .rst(rst),
    .req_flit(req_flit), .req_valid(req_valid), .req_ready(req_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy),
    .hdr_err(hdr_err), .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;

  logic [7:0] q [4][$];
  logic [7:0] obs[$];
  int         gnt[$];
  int         cyc = 0;
  int         hdr_cnt, len_cnt, first_out;
  int         acc [4];
  logic [3:0] fire;
  logic       prev_busy = 1'b0;

  task automatic clear_log();
    obs.delete();
    gnt.delete();
    hdr_cnt   = 0;
    len_cnt   = 0;
    first_out = -1;
    for (int i = 0; i < 4; i++) acc[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (q[i].size() != 0);
      req_flit[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic step();
    drive();
    #1;
    fire = req_valid & req_ready;
    if (out_valid && out_ready) obs.push_back(out_flit);
    if (first_out < 0 && out_valid) first_out = cyc;
    if (busy && !prev_busy) gnt.push_back(int'(grant_id));
    prev_busy = busy;
    if (hdr_err) hdr_cnt++;
    if (len_err) len_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (fire[i]) begin
        void'(q[i].pop_front());
        acc[i]++;
      end
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 ||
                out_valid || busy) && n < max);
    repeat (2) step();
    asserts++;
    if (n >= max) begin
      fails++;
      $display("FAIL drain_bound: got %0d cycles, required < %0d", n, max);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp[$]);
    logic ok;
    ok = (obs.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++) if (obs[i] !== exp[i]) ok = 1'b0;
    asserts++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d flits (first %h), required %0d flits (first %h)",
               name, obs.size(), obs.size() ? obs[0] : 8'h00, exp.size(), exp[0]);
    end
  endtask

  task automatic check_gnt(input string name, input int exp[$]);
    logic ok;
    ok = (gnt.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++) if (gnt[i] != exp[i]) ok = 1'b0;
    asserts++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d grants (first %0d), required %0d grants (first %0d)",
               name, gnt.size(), gnt.size() ? gnt[0] : -1, exp.size(), exp[0]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_busy = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    rst = 1'b1;
    #1;
    asserts++;
    if ({out_valid, out_flit, busy, grant_id, hdr_err, len_err, pkt_count, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0",
               {out_valid, out_flit, busy, grant_id, hdr_err, len_err, pkt_count, req_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    asserts++;
    if ({out_valid, busy, pkt_count} !== '0) begin
      fails++;
      $display("FAIL reset_idle: got %h, required 0", {out_valid, busy, pkt_count});
    end
  endtask

  task automatic test_single();
    int c0;
    clear_log();
    q[2] = '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    c0 = cyc;
    run_idle(40);
    check_seq("single_flits", '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    check_gnt("single_grant", '{2});
    check_val("single_latency", first_out - c0, 2);
    check_val("single_busy", busy, 0);
    check_val("single_pkt_count", pkt_count, 1);
  endtask

  task automatic test_round_robin();
    apply_reset();
    clear_log();
    q[0] = '{8'hBC, 8'h55, 8'hFF, 8'hBC, 8'h55, 8'hFF};
    q[1] = '{8'hBC, 8'h55, 8'hFF};
    q[3] = '{8'hBC, 8'h55, 8'hFF};
    run_idle(80);
    check_gnt("rr_order", '{0, 1, 3, 0});
    check_seq("rr_no_interleave", '{8'hBC, 8'h55, 8'hFF, 8'hBC, 8'h55, 8'hFF,
                                    8'hBC, 8'h55, 8'hFF, 8'hBC, 8'h55, 8'hFF});
    check_val("rr_pkt_count", pkt_count, 4);
  endtask

  task automatic test_garbage();
    clear_log();
    q[1] = '{8'h42};
    run_idle(20);
    check_val("garbage_consumed", q[1].size(), 0);
    check_val("garbage_hdr_err", hdr_cnt, 1);
    check_val("garbage_no_out", first_out, -1);
    check_val("garbage_pkt_count", pkt_count, 4);
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_log();
    q[2] = '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    while (obs.size() < 3 && n < 30) begin
      step();
      n++;
    end
    check_val("bp_reach_stall", obs.size(), 3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("bp_hold_flit", out_flit, 8'h33);
      check_val("bp_ready_low", req_ready[2], 0);
    end
    out_ready = 1'b1;
    run_idle(40);
    check_seq("bp_flits", '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    check_val("bp_pkt_count", pkt_count, 5);
  endtask

  task automatic test_length();
    clear_log();
    q[2] = '{8'hBE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_idle(40);
    check_seq("len_flits", '{8'hBE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    check_val("len_err_pulse", len_cnt, 1);
    check_val("len_leftover_hdr_err", hdr_cnt, 1);
    check_val("len_pkt_count", pkt_count, 5);
    check_val("len_busy", busy, 0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    q[3] = '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    while (acc[3] < 3 && n < 30) begin
      step();
      n++;
    end
    check_val("mid_reached", acc[3], 3);
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    rst = 1'b1;
    #1;
    asserts++;
    if ({out_valid, out_flit, busy, grant_id, hdr_err, len_err, pkt_count, req_ready} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {out_valid, out_flit, busy, grant_id, hdr_err, len_err, pkt_count, req_ready});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_busy = 1'b0;
    clear_log();
    q[2] = '{8'hBC, 8'h55, 8'hFF};
    q[0] = '{8'hBC, 8'h55, 8'hFF};
    run_idle(40);
    check_gnt("mid_next_grant", '{0, 2});
    check_val("mid_pkt_count", pkt_count, 2);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_flit  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_garbage();
    test_backpressure();
    test_length();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
